control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Moore FSM control unit for the single-bus 32-bit datapath. Runs fetch (T0-T2) and execute (T3-T7)
//  for the load/store/ALU/HI-LO instruction set, driving every bus-out select, register-in enable,
//  ALU op code and memory strobe. Sits beside the datapath; consumes IR contents and memory ready.
// PARAMETERS
//  WAIT_MAX  255  max cycles a memory access may wait for mem_ready before mem_fault
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   asynchronous, active-high; forces IDLE, all outputs 0
//  run         in   1   start fetching from IDLE (level)
//  ir          in   32  IR value from datapath
//  mem_ready   in   1   memory done with current read/write
//  r_out       out  16  one-hot Rn bus-drive select
//  r_in        out  16  one-hot Rn load enable
//  pc_out,mdr_out,zhi_out,zlo_out,hi_out,lo_out,c_out  out 1 each  bus-drive selects (c_out = sext ir[18:0])
//  pc_in,ir_in,mar_in,mdr_in,y_in,z_in,hi_in,lo_in     out 1 each  register load enables
//  mdr_load    out  1   MDR source: 1 = memory data, 0 = bus
//  mem_read, mem_write  out 1  memory strobes, held until mem_ready
//  alu_op      out  4   0 ADD,1 SUB,2 AND,3 OR,4 SHR,5 SHL,6 ROR,7 ROL,8 NEG,9 NOT,10 MUL,11 DIV
//  inc_pc      out  1   ALU computes Y-independent PC+1 into Z
//  halted, illegal, mem_fault  out 1  status; sticky until reset
// BEHAVIOUR
//  Fields: op=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15], C=ir[18:0].
//  Opcodes: 00000 ld, 00010 st, 00011 add, 00100 sub, 00101 shr, 00110 shl, 00111 ror, 01000 rol,
//   01001 and, 01010 or, 01011 addi, 01110 mul, 01111 div, 10000 neg, 10001 not, 11000 nop, 11001 halt.
//  States: IDLE, T0..T7, HALT. Outputs decode from state reg + ir only; change only after clk edge.
//  Reset (async): state=IDLE, wait counter=0, every output 0 incl. status flags.
//  IDLE: all 0; run=1 at edge -> T0.
//  T0: pc_out, mar_in, inc_pc, z_in. T1: zlo_out, pc_in, mem_read, mdr_load, mdr_in; stay while
//   !mem_ready (pc_in only on first T1 cycle). T2: mdr_out, ir_in. ir decoded from T3 on.
//  ALU 3-operand (add..or): T3 r_out[Rb],y_in; T4 r_out[Rc],alu_op,z_in; T5 zlo_out,r_in[Ra] -> T0.
//  addi: as above with c_out replacing r_out[Rc] in T4, alu_op=ADD.
//  neg/not: T3 r_out[Rb],alu_op,z_in; T4 zlo_out,r_in[Ra] -> T0.
//  mul/div: T3 r_out[Ra],y_in; T4 r_out[Rb],alu_op,z_in; T5 zlo_out,lo_in; T6 zhi_out,hi_in -> T0.
//  ld: T3 r_out[Rb],y_in; T4 c_out,ADD,z_in; T5 zlo_out,mar_in; T6 mem_read,mdr_load,mdr_in (wait);
//   T7 mdr_out,r_in[Ra] -> T0.
//  st: T3-T5 as ld; T6 r_out[Ra],mdr_in,mdr_load=0; T7 mem_write until mem_ready -> T0.
//  nop: T3 -> T0. halt: T3 -> HALT, halted=1. Undefined op: T3 -> HALT, illegal=1, halted=1.
//  HALT: all enables/strobes 0; exits only via reset; run ignored.
//  Wait counter: counts cycles in a wait state with mem_ready=0; cleared on leaving. Reaching WAIT_MAX
//   -> HALT, mem_fault=1, halted=1; strobes drop same edge.
//  mem_ready sampled only in T1/T6(ld)/T7(st); ignored elsewhere.
//  Invariants: <=1 bus driver per cycle; r_in/r_out at most one bit; at most one of mem_read/mem_write.
//  Reset mid-instruction: outputs drop asynchronously, no partial write committed by this block.
//  Latency, zero wait: ALU/addi 6 cycles, neg/not 5, mul/div/ld/st 7/7/8/8, nop 4.
// TESTING
//  reset, run=1, mem_ready=1, ir=add R1,R2,R3 -> T0..T5 in 6 cycles; T5 r_in=16'h0002, zlo_out=1.
//  mul R4,R5 -> T5 lo_in=1, T6 hi_in=1 & zhi_out=1, back at T0 on cycle 7; alu_op=10 in T4.
//  ld R1,0x10(R2), mem_ready low 3 cycles in T6 -> mem_read held 4 cycles, r_in=16'h0002 in T7.
//  st R3, mem_ready stuck 0 -> after WAIT_MAX cycles mem_fault=1, halted=1, mem_write=0.
//  ir op=11111 -> illegal=1, halted=1 after T3; run toggles ignored; reset clears flags.
//  reset asserted mid-T4 between edges -> all outputs 0 immediately; every cycle check driver invariant.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the single-bus datapath.
// master: sequencer side (consumes run/ir/mem_ready, drives selects, enables, strobes, status).
// slave : datapath/memory side (the mirror image).
interface control_sequencer_if;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;

  logic [15:0] r_out;
  logic [15:0] r_in;
  logic        pc_out, mdr_out, zhi_out, zlo_out, hi_out, lo_out, c_out;
  logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in;
  logic        mdr_load, mem_read, mem_write;
  logic [3:0]  alu_op;
  logic        inc_pc;
  logic        halted, illegal, mem_fault;

  modport master (
    input  run, ir, mem_ready,
    output r_out, r_in,
    output pc_out, mdr_out, zhi_out, zlo_out, hi_out, lo_out, c_out,
    output pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in,
    output mdr_load, mem_read, mem_write, alu_op, inc_pc,
    output halted, illegal, mem_fault
  );

  modport slave (
    output run, ir, mem_ready,
    input  r_out, r_in,
    input  pc_out, mdr_out, zhi_out, zlo_out, hi_out, lo_out, c_out,
    input  pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in,
    input  mdr_load, mem_read, mem_write, alu_op, inc_pc,
    input  halted, illegal, mem_fault
  );
endinterface

// File: rtl/control_sequencer.sv
// Moore control unit for the single-bus 32-bit datapath: fetch in T0-T2, execute in T3-T7.
// Ports: clk, reset (async, active-high), bus (control_sequencer_if.master): run/ir/mem_ready in;
// bus selects, register enables, alu_op, memory strobes and sticky status flags out.
// Control outputs decode from the state register and the (registered) IR only.
module control_sequencer #(
  parameter int unsigned WAIT_MAX = 255
) (
  input logic                 clk,
  input logic                 reset,
  control_sequencer_if.master bus
);
  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);
  localparam int unsigned OP_W  = 5;
  localparam int unsigned REG_W = 4;
  localparam int unsigned RN    = 16;

  localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_AND = 4'd2,  ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4,  ALU_SHL = 4'd5,  ALU_ROR = 4'd6,  ALU_ROL = 4'd7;
  localparam logic [3:0] ALU_NEG = 4'd8,  ALU_NOT = 4'd9,  ALU_MUL = 4'd10, ALU_DIV = 4'd11;

  typedef enum logic [3:0] {
    IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4, T4 = 4'd5,
    T5 = 4'd6, T6 = 4'd7, T7 = 4'd8, HALT = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    C_ALU3, C_ADDI, C_UNARY, C_MULDIV, C_LD, C_ST, C_NOP, C_HALT, C_ILL
  } cls_t;

  state_t            state, state_next;
  cls_t              cls;
  logic [3:0]        op_alu;
  logic [OP_W-1:0]   op;
  logic [REG_W-1:0]  ra, rb, rc;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_next;
  logic              in_wait, timeout, set_illegal;
  logic              unused_ir;

  assign op = bus.ir[31:27];
  assign ra = bus.ir[26:23];
  assign rb = bus.ir[22:19];
  assign rc = bus.ir[18:15];
  // Low constant bits only matter to the datapath sign-extender.
  assign unused_ir = ^bus.ir[14:0];

  function automatic logic [RN-1:0] onehot(input logic [REG_W-1:0] idx);
    onehot = RN'(1) << idx;
  endfunction

  // Opcode -> instruction class and ALU operation.
  always_comb begin
    cls    = C_ILL;
    op_alu = ALU_ADD;
    case (op)
      5'b00000: cls = C_LD;
      5'b00010: cls = C_ST;
      5'b00011: begin cls = C_ALU3;   op_alu = ALU_ADD; end
      5'b00100: begin cls = C_ALU3;   op_alu = ALU_SUB; end
      5'b00101: begin cls = C_ALU3;   op_alu = ALU_SHR; end
      5'b00110: begin cls = C_ALU3;   op_alu = ALU_SHL; end
      5'b00111: begin cls = C_ALU3;   op_alu = ALU_ROR; end
      5'b01000: begin cls = C_ALU3;   op_alu = ALU_ROL; end
      5'b01001: begin cls = C_ALU3;   op_alu = ALU_AND; end
      5'b01010: begin cls = C_ALU3;   op_alu = ALU_OR;  end
      5'b01011: begin cls = C_ADDI;   op_alu = ALU_ADD; end
      5'b01110: begin cls = C_MULDIV; op_alu = ALU_MUL; end
      5'b01111: begin cls = C_MULDIV; op_alu = ALU_DIV; end
      5'b10000: begin cls = C_UNARY;  op_alu = ALU_NEG; end
      5'b10001: begin cls = C_UNARY;  op_alu = ALU_NOT; end
      5'b11000: cls = C_NOP;
      5'b11001: cls = C_HALT;
      default:  cls = C_ILL;
    endcase
  end

  // State register and memory wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next state and Moore output decode.
  always_comb begin
    state_next  = state;
    set_illegal = 1'b0;
    in_wait     = 1'b0;
    bus.r_out   = '0;
    bus.r_in    = '0;
    bus.pc_out  = 1'b0; bus.mdr_out = 1'b0; bus.zhi_out = 1'b0; bus.zlo_out = 1'b0;
    bus.hi_out  = 1'b0; bus.lo_out  = 1'b0; bus.c_out   = 1'b0;
    bus.pc_in   = 1'b0; bus.ir_in   = 1'b0; bus.mar_in  = 1'b0; bus.mdr_in  = 1'b0;
    bus.y_in    = 1'b0; bus.z_in    = 1'b0; bus.hi_in   = 1'b0; bus.lo_in   = 1'b0;
    bus.mdr_load  = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.alu_op    = ALU_ADD;
    bus.inc_pc    = 1'b0;

    case (state)
      IDLE: if (bus.run) state_next = T0;
      T0: begin
        bus.pc_out = 1'b1; bus.mar_in = 1'b1; bus.inc_pc = 1'b1; bus.z_in = 1'b1;
        state_next = T1;
      end
      T1: begin
        bus.zlo_out = 1'b1; bus.mem_read = 1'b1; bus.mdr_load = 1'b1; bus.mdr_in = 1'b1;
        // PC update is a one-shot; later wait cycles must not reload it.
        bus.pc_in = (wait_cnt == '0);
        in_wait   = 1'b1;
        if (bus.mem_ready) state_next = T2;
      end
      T2: begin
        bus.mdr_out = 1'b1; bus.ir_in = 1'b1;
        state_next = T3;
      end
      T3: begin
        state_next = T4;
        case (cls)
          C_ALU3, C_ADDI, C_LD, C_ST: begin bus.r_out = onehot(rb); bus.y_in = 1'b1; end
          C_UNARY:  begin bus.r_out = onehot(rb); bus.alu_op = op_alu; bus.z_in = 1'b1; end
          C_MULDIV: begin bus.r_out = onehot(ra); bus.y_in = 1'b1; end
          C_NOP:    state_next = T0;
          C_HALT:   state_next = HALT;
          default:  begin state_next = HALT; set_illegal = 1'b1; end
        endcase
      end
      T4: begin
        state_next = T5;
        case (cls)
          C_ALU3:   begin bus.r_out = onehot(rc); bus.alu_op = op_alu; bus.z_in = 1'b1; end
          C_ADDI, C_LD, C_ST: begin bus.c_out = 1'b1; bus.alu_op = ALU_ADD; bus.z_in = 1'b1; end
          C_UNARY:  begin bus.zlo_out = 1'b1; bus.r_in = onehot(ra); state_next = T0; end
          C_MULDIV: begin bus.r_out = onehot(rb); bus.alu_op = op_alu; bus.z_in = 1'b1; end
          default:  state_next = T0;
        endcase
      end
      T5: begin
        state_next = T6;
        case (cls)
          C_ALU3, C_ADDI: begin bus.zlo_out = 1'b1; bus.r_in = onehot(ra); state_next = T0; end
          C_MULDIV:       begin bus.zlo_out = 1'b1; bus.lo_in = 1'b1; end
          C_LD, C_ST:     begin bus.zlo_out = 1'b1; bus.mar_in = 1'b1; end
          default:        state_next = T0;
        endcase
      end
      T6: begin
        state_next = T7;
        case (cls)
          C_MULDIV: begin bus.zhi_out = 1'b1; bus.hi_in = 1'b1; state_next = T0; end
          C_LD: begin
            bus.mem_read = 1'b1; bus.mdr_load = 1'b1; bus.mdr_in = 1'b1;
            in_wait = 1'b1;
            if (!bus.mem_ready) state_next = T6;
          end
          C_ST:    begin bus.r_out = onehot(ra); bus.mdr_in = 1'b1; end
          default: state_next = T0;
        endcase
      end
      T7: begin
        state_next = T0;
        case (cls)
          C_LD: begin bus.mdr_out = 1'b1; bus.r_in = onehot(ra); end
          C_ST: begin
            bus.mem_write = 1'b1;
            in_wait = 1'b1;
            if (!bus.mem_ready) state_next = T7;
          end
          default: state_next = T0;
        endcase
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase

    // A stalled access that has waited WAIT_MAX cycles aborts into HALT.
    timeout = in_wait && !bus.mem_ready && (wait_cnt == CNT_W'(WAIT_MAX - 1));
    if (timeout) state_next = HALT;
    wait_cnt_next = (in_wait && !bus.mem_ready && !timeout) ? wait_cnt + CNT_W'(1) : '0;
  end

  // Sticky status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.halted    <= 1'b0;
      bus.illegal   <= 1'b0;
      bus.mem_fault <= 1'b0;
    end else begin
      if (state_next == HALT) bus.halted    <= 1'b1;
      if (set_illegal)        bus.illegal   <= 1'b1;
      if (timeout)            bus.mem_fault <= 1'b1;
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks fetch/execute of several instruction classes
// cycle by cycle against hand-computed control words, plus fault, illegal and reset cases.
module tb_control_sequencer;
  localparam int unsigned WAIT_MAX = 255;

  // Bit positions of the 1-bit controls inside ctl_word().
  localparam int unsigned PC_OUT   = 1 << 18, MDR_OUT = 1 << 17, ZHI_OUT = 1 << 16;
  localparam int unsigned ZLO_OUT  = 1 << 15, HI_OUT  = 1 << 14, LO_OUT  = 1 << 13;
  localparam int unsigned C_OUT    = 1 << 12, PC_IN   = 1 << 11, IR_IN   = 1 << 10;
  localparam int unsigned MAR_IN   = 1 << 9,  MDR_IN  = 1 << 8,  Y_IN    = 1 << 7;
  localparam int unsigned Z_IN     = 1 << 6,  HI_IN   = 1 << 5,  LO_IN   = 1 << 4;
  localparam int unsigned MDR_LOAD = 1 << 3,  MEM_RD  = 1 << 2,  MEM_WR  = 1 << 1;
  localparam int unsigned INC_PC   = 1;

  localparam int unsigned T0_CTL = PC_OUT | MAR_IN | INC_PC | Z_IN;
  localparam int unsigned T1_CTL = ZLO_OUT | MEM_RD | MDR_LOAD | MDR_IN;
  localparam int unsigned T2_CTL = MDR_OUT | IR_IN;

  localparam logic [31:0] IR_ADD  = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
  localparam logic [31:0] IR_MUL  = {5'b01110, 4'd4, 4'd5, 19'd0};
  localparam logic [31:0] IR_NEG  = {5'b10000, 4'd6, 4'd7, 19'd0};
  localparam logic [31:0] IR_ADDI = {5'b01011, 4'd2, 4'd1, 19'd5};
  localparam logic [31:0] IR_NOP  = {5'b11000, 27'd0};
  localparam logic [31:0] IR_LD   = {5'b00000, 4'd1, 4'd2, 19'h10};
  localparam logic [31:0] IR_ST   = {5'b00010, 4'd3, 4'd0, 19'd0};
  localparam logic [31:0] IR_ILL  = {5'b11111, 27'd0};
  localparam logic [31:0] IR_HALT = {5'b11001, 27'd0};

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  control_sequencer_if bus();

  control_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctl_word();
    return {13'd0, bus.pc_out, bus.mdr_out, bus.zhi_out, bus.zlo_out, bus.hi_out, bus.lo_out,
            bus.c_out, bus.pc_in, bus.ir_in, bus.mar_in, bus.mdr_in, bus.y_in, bus.z_in,
            bus.hi_in, bus.lo_in, bus.mdr_load, bus.mem_read, bus.mem_write, bus.inc_pc};
  endfunction

  function automatic logic [31:0] flags();
    return {29'd0, bus.halted, bus.illegal, bus.mem_fault};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input int unsigned ctl, input logic [15:0] ro,
                     input logic [15:0] ri, input logic [3:0] op);
    check({tag, "_ctl"},  ctl_word(), ctl);
    check({tag, "_rout"}, 32'(bus.r_out), 32'(ro));
    check({tag, "_rin"},  32'(bus.r_in), 32'(ri));
    check({tag, "_alu"},  32'(bus.alu_op), 32'(op));
  endtask

  // T0..T2 with `waits` cycles of mem_ready low in T1; loads the new IR during T0.
  task automatic fetch(input int waits, input logic [31:0] ir);
    tick();
    cyc("t0", T0_CTL, 16'h0, 16'h0, 4'd0);
    bus.ir = ir;
    bus.mem_ready = (waits == 0);
    for (int i = 0; i <= waits; i++) begin
      tick();
      cyc("t1", (i == 0) ? (T1_CTL | PC_IN) : T1_CTL, 16'h0, 16'h0, 4'd0);
      if (i == waits) bus.mem_ready = 1'b1;
    end
    tick();
    cyc("t2", T2_CTL, 16'h0, 16'h0, 4'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    cyc("rst", 0, 16'h0, 16'h0, 4'd0);
    check("rst_flags", flags(), 32'd0);
    reset = 1'b0;
  endtask

  // Every cycle: at most one bus driver, one-hot register selects, never both strobes.
  always @(negedge clk) begin
    int drivers;
    drivers = int'(bus.pc_out) + int'(bus.mdr_out) + int'(bus.zhi_out) + int'(bus.zlo_out)
            + int'(bus.hi_out) + int'(bus.lo_out) + int'(bus.c_out) + int'(bus.r_out != 16'h0);
    check("bus_invariant",
          {31'd0, (drivers <= 1) && $onehot0(bus.r_out) && $onehot0(bus.r_in)
                  && !(bus.mem_read && bus.mem_write)}, 32'd1);
  end

  initial begin
    reset = 1'b0;
    bus.run = 1'b0;
    bus.ir = '0;
    bus.mem_ready = 1'b0;
    #1 reset = 1'b1;
    tick();
    cyc("reset", 0, 16'h0, 16'h0, 4'd0);
    check("reset_flags", flags(), 32'd0);

    // Stays idle until run.
    reset = 1'b0;
    tick();
    tick();
    check("idle_ctl", ctl_word(), 32'd0);
    bus.run = 1'b1;
    bus.mem_ready = 1'b1;

    // add R1,R2,R3
    fetch(0, IR_ADD);
    tick(); cyc("add_t3", Y_IN,    16'h0004, 16'h0000, 4'd0);
    tick(); cyc("add_t4", Z_IN,    16'h0008, 16'h0000, 4'd0);
    tick(); cyc("add_t5", ZLO_OUT, 16'h0000, 16'h0002, 4'd0);

    // mul R4,R5
    fetch(0, IR_MUL);
    tick(); cyc("mul_t3", Y_IN,              16'h0010, 16'h0, 4'd0);
    tick(); cyc("mul_t4", Z_IN,              16'h0020, 16'h0, 4'd10);
    tick(); cyc("mul_t5", ZLO_OUT | LO_IN,   16'h0000, 16'h0, 4'd0);
    tick(); cyc("mul_t6", ZHI_OUT | HI_IN,   16'h0000, 16'h0, 4'd0);

    // neg R6,R7
    fetch(0, IR_NEG);
    tick(); cyc("neg_t3", Z_IN,    16'h0080, 16'h0000, 4'd8);
    tick(); cyc("neg_t4", ZLO_OUT, 16'h0000, 16'h0040, 4'd0);

    // addi R2,R1,5
    fetch(0, IR_ADDI);
    tick(); cyc("addi_t3", Y_IN,         16'h0002, 16'h0000, 4'd0);
    tick(); cyc("addi_t4", C_OUT | Z_IN, 16'h0000, 16'h0000, 4'd0);
    tick(); cyc("addi_t5", ZLO_OUT,      16'h0000, 16'h0004, 4'd0);

    // nop, with a two-cycle wait in the instruction fetch
    fetch(2, IR_NOP);
    tick(); cyc("nop_t3", 0, 16'h0, 16'h0, 4'd0);

    // ld R1,0x10(R2) with mem_ready low for three T6 cycles (low in T5 must be ignored)
    fetch(0, IR_LD);
    tick(); cyc("ld_t3", Y_IN,             16'h0004, 16'h0, 4'd0);
    tick(); cyc("ld_t4", C_OUT | Z_IN,     16'h0000, 16'h0, 4'd0);
    tick(); cyc("ld_t5", ZLO_OUT | MAR_IN, 16'h0000, 16'h0, 4'd0);
    bus.mem_ready = 1'b0;
    for (int i = 0; i <= 3; i++) begin
      tick();
      cyc("ld_t6", MEM_RD | MDR_LOAD | MDR_IN, 16'h0, 16'h0, 4'd0);
      if (i == 3) bus.mem_ready = 1'b1;
    end
    tick(); cyc("ld_t7", MDR_OUT, 16'h0000, 16'h0002, 4'd0);

    // st R3,0(R0) with mem_ready stuck low -> fault after WAIT_MAX write cycles
    fetch(0, IR_ST);
    tick(); cyc("st_t3", Y_IN,             16'h0001, 16'h0, 4'd0);
    tick(); cyc("st_t4", C_OUT | Z_IN,     16'h0000, 16'h0, 4'd0);
    tick(); cyc("st_t5", ZLO_OUT | MAR_IN, 16'h0000, 16'h0, 4'd0);
    bus.mem_ready = 1'b0;
    tick(); cyc("st_t6", MDR_IN,           16'h0008, 16'h0, 4'd0);
    for (int i = 0; i < int'(WAIT_MAX); i++) begin
      tick();
      check("st_t7_write", 32'(bus.mem_write), 32'd1);
      if (i == 0) cyc("st_t7", MEM_WR, 16'h0, 16'h0, 4'd0);
    end
    check("st_prefault_flags", flags(), 32'd0);
    tick();
    cyc("st_fault", 0, 16'h0, 16'h0, 4'd0);
    check("st_fault_flags", flags(), 32'b101);
    bus.mem_ready = 1'b1;
    tick();
    check("st_halt_hold", ctl_word(), 32'd0);

    // Undefined opcode -> illegal + halted, run ignored while halted
    do_reset();
    fetch(0, IR_ILL);
    tick(); cyc("ill_t3", 0, 16'h0, 16'h0, 4'd0);
    check("ill_t3_flags", flags(), 32'd0);
    tick();
    check("ill_flags", flags(), 32'b110);
    bus.run = 1'b0;
    tick();
    bus.run = 1'b1;
    tick();
    tick();
    check("ill_run_ignored", ctl_word(), 32'd0);
    check("ill_flags_sticky", flags(), 32'b110);

    // halt instruction: halted without illegal
    do_reset();
    fetch(0, IR_HALT);
    tick(); cyc("halt_t3", 0, 16'h0, 16'h0, 4'd0);
    tick();
    check("halt_flags", flags(), 32'b100);
    check("halt_ctl", ctl_word(), 32'd0);

    // Reset asserted between edges during T4 drops outputs at once
    do_reset();
    fetch(0, IR_ADD);
    tick(); cyc("mid_t3", Y_IN, 16'h0004, 16'h0, 4'd0);
    tick(); cyc("mid_t4", Z_IN, 16'h0008, 16'h0, 4'd0);
    #2 reset = 1'b1;
    #1;
    cyc("async_rst", 0, 16'h0, 16'h0, 4'd0);
    tick();
    reset = 1'b0;
    check("post_rst_ctl", ctl_word(), 32'd0);
    check("post_rst_flags", flags(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
